ppu_palette_reader: RTL and testbench
=====================================

# ppu_palette_reader

Render-side reader of the PPU palette RAM. Each active dot it resolves background/sprite priority, forms the 5-bit palette address, fetches the 6-bit colour from the palette RAM's asynchronous read port, and applies greyscale and emphasis. The qualified colour index and emphasis go to the video encoder. It also maintains the sticky sprite-0 hit flag. It sits between the pixel shifters and sprite evaluator upstream and the palette RAM and video output downstream.

## Interface
Parameters:
- `LEFT_CLIP_W`, default 8: width in dots of the left-edge clip window.

Ports:
- `clk` in 1: PPU clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: dot enable. All state advances only when `ce=1`.
- `pixel_valid` in 1: the current dot is a visible pixel.
- `dot_x` in 8: horizontal pixel position, 0–255.
- `rendering_en` in 1: show_bg OR show_spr.
- `show_bg`, `show_spr`, `show_bg_left`, `show_spr_left` in 1 each: PPUMASK enables.
- `grayscale` in 1: PPUMASK bit 0.
- `emphasis` in 3: PPUMASK bits 7:5.
- `bg_pixel` in 4: {attr[1:0], pattern[1:0]}.
- `spr_pixel` in 4: {palette[1:0], pattern[1:0]}.
- `spr_priority` in 1: 1 means the sprite is behind the background.
- `spr_is0` in 1: the current sprite pixel belongs to OAM entry 0.
- `vram_addr` in 14: current v register, used for the rendering-off backdrop override.
- `pal_addr` out 5: read address to the palette RAM.
- `pal_data` in 6: palette RAM read data, combinational from `pal_addr`.
- `color_out` out 6: final colour index.
- `emph_out` out 3: emphasis bits aligned with `color_out`.
- `color_valid` out 1: `color_out` is valid for this dot.
- `spr0_hit_clr` in 1: clear pulse, asserted at pre-render dot 1.
- `spr0_hit` out 1: sticky sprite-0 hit flag.

## Operation
- Clip: `clip = (dot_x < LEFT_CLIP_W)`.
- Background opacity: `bg_op = show_bg & (bg_pixel[1:0]!=0) & (~clip | show_bg_left)`.
- Sprite opacity: `spr_op = show_spr & (spr_pixel[1:0]!=0) & (~clip | show_spr_left)`.
- Address select when rendering is enabled:
  - `spr_op & (~spr_priority | ~bg_op)` selects `{1,spr_pixel}`.
  - Otherwise `bg_op` selects `{0,bg_pixel}`.
  - Otherwise the address is 5'h00.
- Address select when `rendering_en=0`:
  - If `vram_addr[13:8]==6'h3F`, the address is `vram_addr[4:0]`.
  - Otherwise the address is 5'h00.
- Sprite-palette mirroring (addresses 0x10/14/18/1C) is done inside the palette RAM, not here.
- Stage 1 (ce): register `pal_addr`. Register the stage-1 valid, greyscale and emphasis alongside it.
- Stage 2 (ce): `color_out <= grayscale_s1 ? (pal_data & 6'h30) : pal_data`. Also register `emph_out` and `color_valid`.
- When `pixel_valid=0`, stage 1 still runs, but the valid bit carries 0. `color_out` holds its last value.
- Sprite-0 hit: set when `ce & pixel_valid & rendering_en & bg_op & spr_op & spr_is0 & (dot_x!=255)`. `spr_priority` is ignored for the hit.
- The hit flag is sticky until `spr0_hit_clr`. If set and clear occur in the same cycle, clear wins.

## Timing
- Latency: 2 ce-cycles from inputs to `color_out`/`color_valid`. `pal_addr` is valid 1 ce-cycle after the inputs.
- `ce=0`: every register holds. The pipeline does not drain.
- `spr0_hit` rises on the ce-cycle after the qualifying dot. `spr0_hit_clr` acts regardless of `ce`.
- Reset values: `pal_addr=0`, `color_out=0`, `emph_out=0`, `color_valid=0`, `spr0_hit=0`. Reset mid-line flushes both stages; the first valid output comes 2 ce-cycles after reset drops.
- The palette write port (CPU side) may change the entry being read. The new value is visible at stage 2 when the write lands on or before the stage-1 cycle.

## Configuration
- `PPU_PALETTE_EMPHASIS_EN` defined: `emph_out` follows `emphasis`, pipelined.
- `PPU_PALETTE_EMPHASIS_EN` not defined: `emph_out` is tied to 3'b000 and the emphasis registers are removed. Greyscale is unaffected.

## Structure
- Shared package `ppu_pkg`:
  - `PAL_ADDR_W=5`, `COLOR_W=6`, `BACKDROP_ADDR=5'h00`, `GRAY_MASK=6'h30`.
  - Palette page constant `6'h3F`.
  - Pixel struct {palette[1:0], pattern[1:0]}.
- One combinational sub-module, `ppu_pixel_mux`, holds the opacity, clip and priority logic and the rendering-off override, and produces the address, `bg_op` and `spr_op`. Pipeline registers and the hit flag stay in the top.

## Test plan
- Priority: `bg_pixel=4'b0110`, `spr_pixel=4'b1001`, `spr_priority=0` -> `pal_addr=5'h19`. With `spr_priority=1` -> `pal_addr=5'h06`. `color_out` equals the RAM entry 2 ce-cycles later.
- Transparency and clip: `bg=4'b0100`, `spr=0`, `show_bg_left=0` -> at `dot_x=3`, `pal_addr=0`; at `dot_x=8`, `pal_addr=0` (pattern bits are 0). `bg=4'b0101` at `dot_x=3` -> `pal_addr=0`; at `dot_x=8` -> `pal_addr=5'h05`.
- Rendering-off override: `rendering_en=0`, `vram_addr=14'h3F0B` -> `pal_addr=5'h0B`. `vram_addr=14'h2000` -> `pal_addr=0`.
- Greyscale and emphasis: RAM entry = 6'h2A, `grayscale=1`, `emphasis=3'b101` -> `color_out=6'h20`, `emph_out=3'b101`. Without the macro -> `emph_out=0`.
- Sprite-0 hit:
  - Opaque overlap at `dot_x=100` -> `spr0_hit=1` on the next ce-cycle, held until `spr0_hit_clr`.
  - Overlap at `dot_x=255` -> no hit.
  - Set and clear in the same cycle -> `spr0_hit=0`.
- `ce` stall and reset: hold `ce=0` for 5 cycles mid-stream -> outputs are frozen. Assert `reset` between two valid dots -> all outputs 0, `color_valid` stays 0 for 2 ce-cycles after release.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg
// Shared types and constants for the PPU palette read path.
//   PAL_ADDR_W / COLOR_W : palette address and colour index widths
//   BACKDROP_ADDR        : universal background colour entry
//   GRAY_MASK            : keeps only the luma column of a colour index
//   PALETTE_PAGE         : v[13:8] value that points into palette space
//   pixel_t              : {palette[1:0], pattern[1:0]} shifter/sprite pixel
//   addr_src_e           : which source drives the palette address
package ppu_pkg;

  localparam int PAL_ADDR_W = 5;
  localparam int COLOR_W    = 6;

  localparam logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = 5'h00;
  localparam logic [COLOR_W-1:0]    GRAY_MASK     = 6'h30;
  localparam logic [5:0]            PALETTE_PAGE  = 6'h3F;

  typedef struct packed {
    logic [1:0] palette;
    logic [1:0] pattern;
  } pixel_t;

  typedef enum logic [1:0] {
    SRC_BACKDROP,
    SRC_BG,
    SRC_SPR,
    SRC_VRAM
  } addr_src_e;

  // A pixel is transparent whenever its two pattern bits are zero,
  // regardless of which palette it selects.
  function automatic logic isOpaque(input pixel_t px);
    return (px.pattern != 2'b00);
  endfunction

  // Greyscale drops the hue nibble and keeps only the brightness column.
  function automatic logic [COLOR_W-1:0] applyGray(input logic [COLOR_W-1:0] color,
                                                   input logic               gray);
    return gray ? (color & GRAY_MASK) : color;
  endfunction

endpackage

// File: rtl/ppu_pixel_mux.sv
// ppu_pixel_mux
// Combinational background/sprite priority resolver. Decides whether the
// current dot shows the sprite, the background, the backdrop, or (with
// rendering disabled) the palette entry addressed by the v register.
// Ports:
//   dot_x_i            : horizontal position of the current dot
//   rendering_en_i     : show_bg | show_spr
//   show_*_i           : PPUMASK enables, including the left-edge enables
//   bg_pixel_i         : background pixel {attr, pattern}
//   spr_pixel_i        : sprite pixel {palette, pattern}
//   spr_priority_i     : 1 puts the sprite behind an opaque background
//   vram_addr_i        : v register, used for the rendering-off override
//   addr_o             : resolved palette RAM address
//   bg_op_o / spr_op_o : background / sprite opacity after clipping
module ppu_pixel_mux
  import ppu_pkg::*;
#(
  parameter int LEFT_CLIP_W = 8
) (
  input  logic [7:0]            dot_x_i,
  input  logic                  rendering_en_i,
  input  logic                  show_bg_i,
  input  logic                  show_spr_i,
  input  logic                  show_bg_left_i,
  input  logic                  show_spr_left_i,
  input  logic [3:0]            bg_pixel_i,
  input  logic [3:0]            spr_pixel_i,
  input  logic                  spr_priority_i,
  input  logic [13:0]           vram_addr_i,
  output logic [PAL_ADDR_W-1:0] addr_o,
  output logic                  bg_op_o,
  output logic                  spr_op_o
);

  // Nine bits so a clip window of the full 256-dot line is representable.
  localparam logic [8:0] CLIP_LIMIT = 9'(LEFT_CLIP_W);

  logic      clip;
  pixel_t    bgPx;
  pixel_t    sprPx;
  addr_src_e src;

  // v[7:5] never matter: palette space is only 32 entries deep.
  logic [2:0] unusedVramBits;
  assign unusedVramBits = vram_addr_i[7:5];

  assign bgPx  = pixel_t'(bg_pixel_i);
  assign sprPx = pixel_t'(spr_pixel_i);

  // Left-edge clip window, zero-extended so the compare is unsigned.
  assign clip = ({1'b0, dot_x_i} < CLIP_LIMIT);

  // A layer only counts as opaque when it is enabled, has a non-zero
  // pattern, and is not hidden by the left-edge clip.
  assign bg_op_o  = show_bg_i  & isOpaque(bgPx)  & (~clip | show_bg_left_i);
  assign spr_op_o = show_spr_i & isOpaque(sprPx) & (~clip | show_spr_left_i);

  // Source selection. A front sprite always wins; a back sprite only wins
  // when the background is transparent. With rendering off, the v register
  // may point straight into palette space and override the backdrop.
  always_comb begin
    src = SRC_BACKDROP;
    if (rendering_en_i) begin
      if (spr_op_o & (~spr_priority_i | ~bg_op_o)) begin
        src = SRC_SPR;
      end else if (bg_op_o) begin
        src = SRC_BG;
      end
    end else if (vram_addr_i[13:8] == PALETTE_PAGE) begin
      src = SRC_VRAM;
    end
  end

  // Address formation: bit 4 selects the sprite half of palette RAM.
  always_comb begin
    addr_o = BACKDROP_ADDR;
    case (src)
      SRC_SPR:  addr_o = {1'b1, sprPx};
      SRC_BG:   addr_o = {1'b0, bgPx};
      SRC_VRAM: addr_o = vram_addr_i[4:0];
      default:  addr_o = BACKDROP_ADDR;
    endcase
  end

endmodule

// File: rtl/ppu_palette_reader.sv
// ppu_palette_reader
// Render-side palette reader. Each enabled dot it resolves priority, issues
// a palette RAM address, captures the colour one dot later, applies
// greyscale/emphasis and presents the result to the video encoder. It also
// keeps the sticky sprite-0 hit flag.
// Optional feature macro: PPU_PALETTE_EMPHASIS_EN (pipelined emphasis bits;
// when undefined emph_out_o is constant zero).
// Ports:
//   clk_i, reset_i     : PPU clock, synchronous active-high reset
//   ce_i               : dot enable, all state holds when low
//   pixel_valid_i      : current dot is a visible pixel
//   dot_x_i            : horizontal position 0..255
//   rendering_en_i     : show_bg | show_spr
//   show_*_i           : PPUMASK layer and left-edge enables
//   grayscale_i        : PPUMASK greyscale
//   emphasis_i         : PPUMASK emphasis bits
//   bg_pixel_i         : background pixel {attr, pattern}
//   spr_pixel_i        : sprite pixel {palette, pattern}
//   spr_priority_i     : sprite behind background
//   spr_is0_i          : sprite pixel comes from OAM entry 0
//   vram_addr_i        : v register for the rendering-off override
//   pal_addr_o         : palette RAM read address (registered)
//   pal_data_i         : palette RAM async read data
//   color_out_o        : final colour index
//   emph_out_o         : emphasis aligned with color_out_o
//   color_valid_o      : color_out_o belongs to a visible dot
//   spr0_hit_clr_i     : clear pulse for the hit flag
//   spr0_hit_o         : sticky sprite-0 hit
module ppu_palette_reader
  import ppu_pkg::*;
#(
  parameter int LEFT_CLIP_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ce_i,
  input  logic                  pixel_valid_i,
  input  logic [7:0]            dot_x_i,
  input  logic                  rendering_en_i,
  input  logic                  show_bg_i,
  input  logic                  show_spr_i,
  input  logic                  show_bg_left_i,
  input  logic                  show_spr_left_i,
  input  logic                  grayscale_i,
  input  logic [2:0]            emphasis_i,
  input  logic [3:0]            bg_pixel_i,
  input  logic [3:0]            spr_pixel_i,
  input  logic                  spr_priority_i,
  input  logic                  spr_is0_i,
  input  logic [13:0]           vram_addr_i,
  output logic [PAL_ADDR_W-1:0] pal_addr_o,
  input  logic [COLOR_W-1:0]    pal_data_i,
  output logic [COLOR_W-1:0]    color_out_o,
  output logic [2:0]            emph_out_o,
  output logic                  color_valid_o,
  input  logic                  spr0_hit_clr_i,
  output logic                  spr0_hit_o
);

  logic [PAL_ADDR_W-1:0] muxAddr;
  logic                  bgOp;
  logic                  sprOp;
  logic                  hitEvent;

  logic [PAL_ADDR_W-1:0] palAddr_q, palAddr_d;
  logic                  valid1_q, valid1_d;
  logic                  gray1_q, gray1_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  logic                  colorValid_q, colorValid_d;
  logic                  hit_q, hit_d;

  ppu_pixel_mux #(
    .LEFT_CLIP_W(LEFT_CLIP_W)
  ) u_mux (
    .dot_x_i         (dot_x_i),
    .rendering_en_i  (rendering_en_i),
    .show_bg_i       (show_bg_i),
    .show_spr_i      (show_spr_i),
    .show_bg_left_i  (show_bg_left_i),
    .show_spr_left_i (show_spr_left_i),
    .bg_pixel_i      (bg_pixel_i),
    .spr_pixel_i     (spr_pixel_i),
    .spr_priority_i  (spr_priority_i),
    .vram_addr_i     (vram_addr_i),
    .addr_o          (muxAddr),
    .bg_op_o         (bgOp),
    .spr_op_o        (sprOp)
  );

  // Pipeline next-state. Stage 1 latches the address and side info every
  // enabled dot, blank dots included, so pal_addr_o keeps tracking the
  // v register while rendering is off. Stage 2 only updates the colour
  // for visible dots so the encoder sees the last real pixel during blanking.
  // The palette RAM is read at stage 2, so a CPU write that lands by the
  // stage-1 cycle is already reflected here.
  always_comb begin
    palAddr_d    = palAddr_q;
    valid1_d     = valid1_q;
    gray1_d      = gray1_q;
    color_d      = color_q;
    colorValid_d = colorValid_q;
    if (ce_i) begin
      palAddr_d    = muxAddr;
      valid1_d     = pixel_valid_i;
      gray1_d      = grayscale_i;
      colorValid_d = valid1_q;
      if (valid1_q) begin
        color_d = applyGray(pal_data_i, gray1_q);
      end
    end
  end

  // Pipeline registers. Reset flushes both stages so nothing stale is
  // marked valid after a mid-line reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      palAddr_q    <= BACKDROP_ADDR;
      valid1_q     <= 1'b0;
      gray1_q      <= 1'b0;
      color_q      <= '0;
      colorValid_q <= 1'b0;
    end else begin
      palAddr_q    <= palAddr_d;
      valid1_q     <= valid1_d;
      gray1_q      <= gray1_d;
      color_q      <= color_d;
      colorValid_q <= colorValid_d;
    end
  end

  // A hit needs both layers opaque on a visible, rendering dot from OAM
  // entry 0. Sprite priority is irrelevant, and the last column never hits.
  assign hitEvent = ce_i & pixel_valid_i & rendering_en_i & bgOp & sprOp &
                    spr_is0_i & (dot_x_i != 8'd255);

  // Sticky hit flag. The clear pulse is honoured even on disabled dots and
  // beats a simultaneous set.
  always_comb begin
    hit_d = hit_q;
    if (spr0_hit_clr_i) begin
      hit_d = 1'b0;
    end else if (hitEvent) begin
      hit_d = 1'b1;
    end
  end

  // Hit flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

`ifdef PPU_PALETTE_EMPHASIS_EN
  logic [2:0] emph1_q, emph1_d;
  logic [2:0] emphOut_q, emphOut_d;

  // Emphasis follows the colour through both stages so the encoder sees
  // the tint that was active when the dot was resolved.
  always_comb begin
    emph1_d   = emph1_q;
    emphOut_d = emphOut_q;
    if (ce_i) begin
      emph1_d = emphasis_i;
      if (valid1_q) begin
        emphOut_d = emph1_q;
      end
    end
  end

  // Emphasis pipeline registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      emph1_q   <= '0;
      emphOut_q <= '0;
    end else begin
      emph1_q   <= emph1_d;
      emphOut_q <= emphOut_d;
    end
  end

  assign emph_out_o = emphOut_q;
`else
  // Emphasis disabled: the input is intentionally ignored.
  logic [2:0] unusedEmphasis;
  assign unusedEmphasis = emphasis_i;
  assign emph_out_o     = 3'b000;
`endif

  assign pal_addr_o    = palAddr_q;
  assign color_out_o   = color_q;
  assign color_valid_o = colorValid_q;
  assign spr0_hit_o    = hit_q;

endmodule

// File: tb/tb_ppu_palette_reader.sv
// tb_ppu_palette_reader
// Self-checking bench: directed vector table for priority/clip/override,
// hand-written sequences for greyscale, emphasis and sprite-0 hit, and a
// randomized run (with stalls and a mid-stream reset) compared against a
// dot-level reference model.
module tb_ppu_palette_reader;

  localparam int CLIP_W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       pixel_valid;
  logic [7:0] dot_x;
  logic       rendering_en;
  logic       show_bg, show_spr, show_bg_left, show_spr_left;
  logic       grayscale;
  logic [2:0] emphasis;
  logic [3:0] bg_pixel, spr_pixel;
  logic       spr_priority, spr_is0;
  logic [13:0] vram_addr;
  logic [4:0] pal_addr;
  logic [5:0] pal_data;
  logic [5:0] color_out;
  logic [2:0] emph_out;
  logic       color_valid;
  logic       spr0_hit_clr;
  logic       spr0_hit;

  logic [5:0] ram [32];
  assign pal_data = ram[pal_addr];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_palette_reader #(.LEFT_CLIP_W(CLIP_W)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .ce_i            (ce),
    .pixel_valid_i   (pixel_valid),
    .dot_x_i         (dot_x),
    .rendering_en_i  (rendering_en),
    .show_bg_i       (show_bg),
    .show_spr_i      (show_spr),
    .show_bg_left_i  (show_bg_left),
    .show_spr_left_i (show_spr_left),
    .grayscale_i     (grayscale),
    .emphasis_i      (emphasis),
    .bg_pixel_i      (bg_pixel),
    .spr_pixel_i     (spr_pixel),
    .spr_priority_i  (spr_priority),
    .spr_is0_i       (spr_is0),
    .vram_addr_i     (vram_addr),
    .pal_addr_o      (pal_addr),
    .pal_data_i      (pal_data),
    .color_out_o     (color_out),
    .emph_out_o      (emph_out),
    .color_valid_o   (color_valid),
    .spr0_hit_clr_i  (spr0_hit_clr),
    .spr0_hit_o      (spr0_hit)
  );

  typedef struct packed {
    logic        ce;
    logic        valid;
    logic        renderEn;
    logic        showBg;
    logic        showSpr;
    logic        showBgLeft;
    logic        showSprLeft;
    logic        gray;
    logic        prio;
    logic        is0;
    logic [7:0]  dotX;
    logic [2:0]  emph;
    logic [3:0]  bg;
    logic [3:0]  spr;
    logic [13:0] vram;
  } dot_t;

  typedef struct {
    dot_t       in;
    logic [4:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, kept at the level of "what the last enabled dot was".
  logic       mPrevValid;
  logic [4:0] mPrevAddr;
  logic       mPrevGray;
  logic [2:0] mPrevEmph;
  logic [4:0] mAddr;
  logic [5:0] mColor;
  logic [2:0] mEmph;
  logic       mValid;
  logic       mHit;

  // Builds a dot with common defaults: visible, enabled, no greyscale.
  function automatic dot_t mkDot(input logic [7:0] x, input logic showB, input logic showS,
                                 input logic bgL, input logic sprL, input logic [3:0] bg,
                                 input logic [3:0] spr, input logic prio, input logic rend,
                                 input logic [13:0] vram);
    dot_t d;
    d = '0;
    d.ce = 1'b1; d.valid = 1'b1; d.renderEn = rend;
    d.showBg = showB; d.showSpr = showS; d.showBgLeft = bgL; d.showSprLeft = sprL;
    d.dotX = x; d.bg = bg; d.spr = spr; d.prio = prio; d.vram = vram;
    return d;
  endfunction

  // Palette address the spec's priority rules pick for one dot.
  function automatic logic [4:0] refAddr(input dot_t d);
    bit clip, bgOpaque, sprOpaque;
    clip      = (int'(d.dotX) < CLIP_W);
    bgOpaque  = d.showBg  && (d.bg[1:0]  != 2'b00) && (!clip || d.showBgLeft);
    sprOpaque = d.showSpr && (d.spr[1:0] != 2'b00) && (!clip || d.showSprLeft);
    if (!d.renderEn) return (d.vram[13:8] == 6'h3F) ? d.vram[4:0] : 5'h00;
    if (sprOpaque && (!d.prio || !bgOpaque)) return {1'b1, d.spr};
    if (bgOpaque) return {1'b0, d.bg};
    return 5'h00;
  endfunction

  function automatic bit refHit(input dot_t d);
    bit clip, bgOpaque, sprOpaque;
    clip      = (int'(d.dotX) < CLIP_W);
    bgOpaque  = d.showBg  && (d.bg[1:0]  != 2'b00) && (!clip || d.showBgLeft);
    sprOpaque = d.showSpr && (d.spr[1:0] != 2'b00) && (!clip || d.showSprLeft);
    return d.ce && d.valid && d.renderEn && bgOpaque && sprOpaque && d.is0 && (d.dotX != 8'd255);
  endfunction

  function automatic logic [2:0] expEmphasis(input logic [2:0] e);
`ifdef PPU_PALETTE_EMPHASIS_EN
    return e;
`else
    return 3'b000 & e;
`endif
  endfunction

  // Advances the model by one clock with the given dot, reset and clear.
  task automatic modelCycle(input dot_t d, input logic rst, input logic clr);
    if (rst) begin
      mPrevValid = 0; mPrevAddr = 0; mPrevGray = 0; mPrevEmph = 0;
      mAddr = 0; mColor = 0; mEmph = 0; mValid = 0; mHit = 0;
    end else begin
      if (clr) mHit = 0;
      else if (refHit(d)) mHit = 1;
      if (d.ce) begin
        mValid = mPrevValid;
        if (mPrevValid) begin
          mColor = mPrevGray ? (ram[mPrevAddr] & 6'h30) : ram[mPrevAddr];
          mEmph  = expEmphasis(mPrevEmph);
        end
        mPrevValid = d.valid;
        mPrevAddr  = refAddr(d);
        mPrevGray  = d.gray;
        mPrevEmph  = d.emph;
        mAddr      = mPrevAddr;
      end
    end
  endtask

  task automatic applyStimulus(input dot_t d);
    ce = d.ce; pixel_valid = d.valid; dot_x = d.dotX; rendering_en = d.renderEn;
    show_bg = d.showBg; show_spr = d.showSpr; show_bg_left = d.showBgLeft;
    show_spr_left = d.showSprLeft; grayscale = d.gray; emphasis = d.emph;
    bg_pixel = d.bg; spr_pixel = d.spr; spr_priority = d.prio; spr_is0 = d.is0;
    vram_addr = d.vram;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " pal_addr"}, 32'(pal_addr), 32'(mAddr));
    checkOutput({tag, " color_out"}, 32'(color_out), 32'(mColor));
    checkOutput({tag, " emph_out"}, 32'(emph_out), 32'(mEmph));
    checkOutput({tag, " color_valid"}, 32'(color_valid), 32'(mValid));
    checkOutput({tag, " spr0_hit"}, 32'(spr0_hit), 32'(mHit));
  endtask

  function automatic dot_t randomDot();
    dot_t d;
    d = dot_t'({$urandom, $urandom});
    case ($urandom_range(0, 2))
      0: d.dotX = 8'($urandom_range(0, 15));
      1: d.dotX = 8'($urandom_range(248, 255));
      default: d.dotX = 8'($urandom);
    endcase
    d.ce    = ($urandom_range(0, 3) != 0);
    d.valid = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 1) == 1) d.vram[13:8] = 6'h3F;
    return d;
  endfunction

  initial begin
    dot_t d;
    vec_t v;
    logic rst, clr;

    for (int i = 0; i < 32; i++) ram[i] = 6'((i * 7 + 3) % 64);
    spr0_hit_clr = 0;
    reset = 1;
    d = mkDot(8'd50, 1, 1, 1, 1, 4'h0, 4'h0, 0, 1, 14'h0000);
    applyStimulus(d);
    step();
    step();
    checkOutput("reset pal_addr", 32'(pal_addr), 0);
    checkOutput("reset color_out", 32'(color_out), 0);
    checkOutput("reset emph_out", 32'(emph_out), 0);
    checkOutput("reset color_valid", 32'(color_valid), 0);
    checkOutput("reset spr0_hit", 32'(spr0_hit), 0);
    reset = 0;

    // Directed priority / clip / override table.
    v.in = mkDot(8'd50, 1, 1, 1, 1, 4'b0110, 4'b1001, 0, 1, 14'h0); v.expAddr = 5'h19; vecs.push_back(v);
    v.in = mkDot(8'd50, 1, 1, 1, 1, 4'b0110, 4'b1001, 1, 1, 14'h0); v.expAddr = 5'h06; vecs.push_back(v);
    v.in = mkDot(8'd3,  1, 1, 0, 1, 4'b0100, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd8,  1, 1, 0, 1, 4'b0100, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd3,  1, 1, 0, 1, 4'b0101, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd8,  1, 1, 0, 1, 4'b0101, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h05; vecs.push_back(v);
    v.in = mkDot(8'd7,  1, 1, 0, 1, 4'b0101, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd50, 0, 0, 1, 1, 4'b0110, 4'b1001, 0, 0, 14'h3F0B); v.expAddr = 5'h0B; vecs.push_back(v);
    v.in = mkDot(8'd50, 0, 0, 1, 1, 4'b0110, 4'b1001, 0, 0, 14'h2000); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd7,  1, 1, 1, 0, 4'b0110, 4'b1001, 0, 1, 14'h0); v.expAddr = 5'h06; vecs.push_back(v);
    v.in = mkDot(8'd50, 1, 1, 1, 1, 4'b0110, 4'b1100, 0, 1, 14'h0); v.expAddr = 5'h06; vecs.push_back(v);
    v.in = mkDot(8'd50, 0, 1, 1, 1, 4'b0110, 4'b0000, 0, 1, 14'h0); v.expAddr = 5'h00; vecs.push_back(v);
    v.in = mkDot(8'd255, 1, 1, 1, 1, 4'b0100, 4'b1001, 1, 1, 14'h0); v.expAddr = 5'h19; vecs.push_back(v);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      step();
      checkOutput($sformatf("vec%0d pal_addr", i), 32'(pal_addr), 32'(vecs[i].expAddr));
      step();
      checkOutput($sformatf("vec%0d color_out", i), 32'(color_out), 32'(ram[vecs[i].expAddr]));
      checkOutput($sformatf("vec%0d color_valid", i), 32'(color_valid), 1);
    end

    // Greyscale and emphasis on entry 5 holding 0x2A.
    ram[5] = 6'h2A;
    d = mkDot(8'd50, 1, 1, 1, 1, 4'b0101, 4'b0000, 0, 1, 14'h0);
    d.gray = 1; d.emph = 3'b101;
    applyStimulus(d);
    step();
    step();
    checkOutput("gray color_out", 32'(color_out), 32'h20);
    checkOutput("gray emph_out", 32'(emph_out), 32'(expEmphasis(3'b101)));
    d.gray = 0; d.emph = 3'b010;
    applyStimulus(d);
    step();
    step();
    checkOutput("nogray color_out", 32'(color_out), 32'h2A);
    checkOutput("nogray emph_out", 32'(emph_out), 32'(expEmphasis(3'b010)));

    // Sprite-0 hit sequences.
    spr0_hit_clr = 1; step(); spr0_hit_clr = 0;
    d = mkDot(8'd100, 1, 1, 1, 1, 4'b0110, 4'b1001, 0, 1, 14'h0);
    d.is0 = 1;
    applyStimulus(d);
    step();
    checkOutput("hit set", 32'(spr0_hit), 1);
    d.is0 = 0; applyStimulus(d);
    step(); step(); step();
    checkOutput("hit sticky", 32'(spr0_hit), 1);
    spr0_hit_clr = 1; step(); spr0_hit_clr = 0;
    checkOutput("hit cleared", 32'(spr0_hit), 0);
    d.is0 = 1; d.dotX = 8'd255; applyStimulus(d);
    step();
    checkOutput("hit x255", 32'(spr0_hit), 0);
    d.dotX = 8'd100; applyStimulus(d);
    spr0_hit_clr = 1; step();
    checkOutput("hit set+clr", 32'(spr0_hit), 0);
    spr0_hit_clr = 0; step();
    checkOutput("hit reset after clr", 32'(spr0_hit), 1);
    d.ce = 0; d.is0 = 0; applyStimulus(d);
    spr0_hit_clr = 1; step(); spr0_hit_clr = 0;
    checkOutput("hit clr with ce=0", 32'(spr0_hit), 0);
    d.ce = 1; d.is0 = 1; d.prio = 1; applyStimulus(d);
    step();
    checkOutput("hit behind bg", 32'(spr0_hit), 1);

    // Randomized run against the model, with a forced stall and a reset.
    for (int i = 0; i < 32; i++) ram[i] = 6'($urandom);
    d = randomDot();
    applyStimulus(d);
    reset = 1; step(); modelCycle(d, 1'b1, 1'b0); reset = 0;
    checkModel("rand reset");
    for (int cyc = 0; cyc < 400; cyc++) begin
      d   = randomDot();
      rst = (cyc == 250);
      clr = ($urandom_range(0, 19) == 0);
      if (cyc >= 150 && cyc < 155) d.ce = 0;
      if (cyc >= 251 && cyc < 253) begin d.ce = 1; d.valid = 1; end
      applyStimulus(d);
      reset = rst;
      spr0_hit_clr = clr;
      step();
      modelCycle(d, rst, clr);
      checkModel($sformatf("rand%0d", cyc));
    end
    reset = 0;
    spr0_hit_clr = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
